// File: rtl/rstation_append.sv
// Tomasulo reservation-station bank: three 3-entry pools (add, mul, branch)
// with CDB wakeup and one dispatch per pool per cycle.
module rstation_append (
  input  logic        clk,
  input  logic        reset,
  input  logic        count,
  input  logic        rs1b,
  input  logic        rs2b,
  input  logic [15:0] rs1,
  input  logic [15:0] rs2,
  input  logic [2:0]  rob_ind,
  input  logic [3:0]  func,
  input  logic [3:0]  rd,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_tag,
  input  logic [15:0] cdb_data,
  output logic        accept,
  output logic [1:0]  add_count,
  output logic [1:0]  mul_count,
  output logic [1:0]  bch_count,
  output logic        add_disp_valid,
  output logic [3:0]  add_disp_func,
  output logic [15:0] add_disp_vj,
  output logic [15:0] add_disp_vk,
  output logic [2:0]  add_disp_rob,
  output logic [3:0]  add_disp_rd,
  output logic        mul_disp_valid,
  output logic [3:0]  mul_disp_func,
  output logic [15:0] mul_disp_vj,
  output logic [15:0] mul_disp_vk,
  output logic [2:0]  mul_disp_rob,
  output logic [3:0]  mul_disp_rd,
  output logic        bch_disp_valid,
  output logic [3:0]  bch_disp_func,
  output logic [15:0] bch_disp_vj,
  output logic [15:0] bch_disp_vk,
  output logic [2:0]  bch_disp_rob,
  output logic [3:0]  bch_disp_rd
);

  logic [2:0][2:0] busy, qjv, qkv, busy_nxt, rdy;
  logic [3:0]  e_func [3][3];
  logic [3:0]  e_rd   [3][3];
  logic [2:0]  e_rob  [3][3];
  logic [2:0]  e_qj   [3][3];
  logic [2:0]  e_qk   [3][3];
  logic [15:0] e_vj   [3][3];
  logic [15:0] e_vk   [3][3];

  logic [2:0]  d_valid;
  logic [3:0]  d_func [3];
  logic [15:0] d_vj   [3];
  logic [15:0] d_vk   [3];
  logic [2:0]  d_rob  [3];
  logic [3:0]  d_rd   [3];
  logic [1:0]  cnt    [3];

  logic [1:0] pool, asel;
  logic [1:0] dsel [3];
  logic [2:0] free;
  logic       hit1, hit2;

  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  function automatic logic [1:0] pop3(input logic [2:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

  assign hit1 = cdb_valid && (cdb_tag == rs1[2:0]);
  assign hit2 = cdb_valid && (cdb_tag == rs2[2:0]);

  always_comb begin
    unique case (func[2:1])
      2'b00:   pool = 2'd0;
      2'b01:   pool = 2'd1;
      default: pool = 2'd2;
    endcase
    free   = ~busy[pool];
    asel   = lowest(free);
    accept = count & ~func[3] & (|free);
    busy_nxt = busy;
    for (int p = 0; p < 3; p++) begin
      rdy[p]  = busy[p] & ~qjv[p] & ~qkv[p];
      dsel[p] = lowest(rdy[p]);
      if (|rdy[p]) busy_nxt[p][dsel[p]] = 1'b0;
    end
    // a slot freed by this edge's dispatch is never reused in the same edge
    if (accept) busy_nxt[pool][asel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= '0;
      qjv     <= '0;
      qkv     <= '0;
      d_valid <= '0;
      for (int p = 0; p < 3; p++) begin
        cnt[p]    <= '0;
        d_func[p] <= '0;
        d_vj[p]   <= '0;
        d_vk[p]   <= '0;
        d_rob[p]  <= '0;
        d_rd[p]   <= '0;
        for (int e = 0; e < 3; e++) begin
          e_func[p][e] <= '0;
          e_rd[p][e]   <= '0;
          e_rob[p][e]  <= '0;
          e_qj[p][e]   <= '0;
          e_qk[p][e]   <= '0;
          e_vj[p][e]   <= '0;
          e_vk[p][e]   <= '0;
        end
      end
    end else begin
      busy <= busy_nxt;
      for (int p = 0; p < 3; p++) begin
        cnt[p] <= pop3(busy_nxt[p]);
        for (int e = 0; e < 3; e++) begin
          if (cdb_valid && busy[p][e] && qjv[p][e]
              && e_qj[p][e] == cdb_tag) begin
            e_vj[p][e] <= cdb_data;
            qjv[p][e]  <= 1'b0;
          end
          if (cdb_valid && busy[p][e] && qkv[p][e]
              && e_qk[p][e] == cdb_tag) begin
            e_vk[p][e] <= cdb_data;
            qkv[p][e]  <= 1'b0;
          end
        end
        d_valid[p] <= |rdy[p];
        if (|rdy[p]) begin
          d_func[p] <= e_func[p][dsel[p]];
          d_vj[p]   <= e_vj[p][dsel[p]];
          d_vk[p]   <= e_vk[p][dsel[p]];
          d_rob[p]  <= e_rob[p][dsel[p]];
          d_rd[p]   <= e_rd[p][dsel[p]];
        end
      end
      if (accept) begin
        e_func[pool][asel] <= func;
        e_rd[pool][asel]   <= rd;
        e_rob[pool][asel]  <= rob_ind;
        e_qj[pool][asel]   <= rs1[2:0];
        e_qk[pool][asel]   <= rs2[2:0];
        e_vj[pool][asel]   <= rs1b ? rs1 : (hit1 ? cdb_data : 16'd0);
        e_vk[pool][asel]   <= rs2b ? rs2 : (hit2 ? cdb_data : 16'd0);
        qjv[pool][asel]    <= ~rs1b & ~hit1;
        qkv[pool][asel]    <= ~rs2b & ~hit2;
      end
    end
  end

  assign add_count = cnt[0];
  assign mul_count = cnt[1];
  assign bch_count = cnt[2];

  assign add_disp_valid = d_valid[0];
  assign add_disp_func  = d_func[0];
  assign add_disp_vj    = d_vj[0];
  assign add_disp_vk    = d_vk[0];
  assign add_disp_rob   = d_rob[0];
  assign add_disp_rd    = d_rd[0];

  assign mul_disp_valid = d_valid[1];
  assign mul_disp_func  = d_func[1];
  assign mul_disp_vj    = d_vj[1];
  assign mul_disp_vk    = d_vk[1];
  assign mul_disp_rob   = d_rob[1];
  assign mul_disp_rd    = d_rd[1];

  assign bch_disp_valid = d_valid[2];
  assign bch_disp_func  = d_func[2];
  assign bch_disp_vj    = d_vj[2];
  assign bch_disp_vk    = d_vk[2];
  assign bch_disp_rob   = d_rob[2];
  assign bch_disp_rd    = d_rd[2];

endmodule

// File: tb/tb_rstation_append.sv
// Scoreboard bench for rstation_append: expected dispatches are queued
// per pool at issue time and compared when each dispatch pulse appears.
module tb_rstation_append;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        count = 1'b0;
  logic        rs1b = 1'b0, rs2b = 1'b0;
  logic [15:0] rs1 = '0, rs2 = '0;
  logic [2:0]  rob_ind = '0;
  logic [3:0]  func = '0, rd = '0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;

  logic        accept;
  logic [1:0]  add_count, mul_count, bch_count;
  logic        add_disp_valid, mul_disp_valid, bch_disp_valid;
  logic [3:0]  add_disp_func, mul_disp_func, bch_disp_func;
  logic [15:0] add_disp_vj, mul_disp_vj, bch_disp_vj;
  logic [15:0] add_disp_vk, mul_disp_vk, bch_disp_vk;
  logic [2:0]  add_disp_rob, mul_disp_rob, bch_disp_rob;
  logic [3:0]  add_disp_rd, mul_disp_rd, bch_disp_rd;

  int checks = 0;
  int failures = 0;
  logic [42:0] q_add[$];
  logic [42:0] q_mul[$];
  logic [42:0] q_bch[$];

  always #5 clk = ~clk;

  rstation_append dut (
    .clk(clk), .reset(reset), .count(count),
    .rs1b(rs1b), .rs2b(rs2b), .rs1(rs1), .rs2(rs2),
    .rob_ind(rob_ind), .func(func), .rd(rd),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .accept(accept),
    .add_count(add_count), .mul_count(mul_count), .bch_count(bch_count),
    .add_disp_valid(add_disp_valid), .add_disp_func(add_disp_func),
    .add_disp_vj(add_disp_vj), .add_disp_vk(add_disp_vk),
    .add_disp_rob(add_disp_rob), .add_disp_rd(add_disp_rd),
    .mul_disp_valid(mul_disp_valid), .mul_disp_func(mul_disp_func),
    .mul_disp_vj(mul_disp_vj), .mul_disp_vk(mul_disp_vk),
    .mul_disp_rob(mul_disp_rob), .mul_disp_rd(mul_disp_rd),
    .bch_disp_valid(bch_disp_valid), .bch_disp_func(bch_disp_func),
    .bch_disp_vj(bch_disp_vj), .bch_disp_vk(bch_disp_vk),
    .bch_disp_rob(bch_disp_rob), .bch_disp_rd(bch_disp_rd)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0]  f,
                       input logic        b1,
                       input logic [15:0] r1,
                       input logic        b2,
                       input logic [15:0] r2,
                       input logic [2:0]  rb,
                       input logic [3:0]  d,
                       input logic        exp_acc,
                       input logic [15:0] ej,
                       input logic [15:0] ek);
    count = 1'b1; func = f; rs1b = b1; rs1 = r1;
    rs2b = b2; rs2 = r2; rob_ind = rb; rd = d;
    #1;
    check("accept", {63'd0, accept}, {63'd0, exp_acc});
    if (exp_acc) begin
      if (f[2])      q_bch.push_back({f, ej, ek, rb, d});
      else if (f[1]) q_mul.push_back({f, ej, ek, rb, d});
      else           q_add.push_back({f, ej, ek, rb, d});
    end
    step();
    count = 1'b0;
  endtask

  task automatic pop_chk(input int p, input logic [42:0] got);
    logic [42:0] e;
    int n;
    n = (p == 0) ? q_add.size() : (p == 1) ? q_mul.size() : q_bch.size();
    check("disp_expected", {63'd0, n > 0}, 64'd1);
    if (n > 0) begin
      if (p == 0)      e = q_add.pop_front();
      else if (p == 1) e = q_mul.pop_front();
      else             e = q_bch.pop_front();
      check(p == 0 ? "add_disp" : p == 1 ? "mul_disp" : "bch_disp",
            {21'd0, got}, {21'd0, e});
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (add_disp_valid)
        pop_chk(0, {add_disp_func, add_disp_vj, add_disp_vk,
                    add_disp_rob, add_disp_rd});
      if (mul_disp_valid)
        pop_chk(1, {mul_disp_func, mul_disp_vj, mul_disp_vk,
                    mul_disp_rob, mul_disp_rd});
      if (bch_disp_valid)
        pop_chk(2, {bch_disp_func, bch_disp_vj, bch_disp_vk,
                    bch_disp_rob, bch_disp_rd});
    end
  end

  initial begin
    step(); step();
    reset = 1'b0;
    check("rst_add_cnt", {62'd0, add_count}, 64'd0);
    check("rst_mul_cnt", {62'd0, mul_count}, 64'd0);
    check("rst_bch_cnt", {62'd0, bch_count}, 64'd0);
    check("rst_dv", {61'd0, add_disp_valid, mul_disp_valid, bch_disp_valid}, 64'd0);

    // ready add: 1-cycle residency
    offer(4'b0000, 1, 16'd5, 1, 16'd7, 3'd2, 4'd3, 1, 16'd5, 16'd7);
    check("add_cnt1", {62'd0, add_count}, 64'd1);
    step();
    check("add_cnt0", {62'd0, add_count}, 64'd0);

    // pending muls waiting on tag 6; fourth is refused
    for (int i = 0; i < 4; i++)
      offer(4'b0010 | 4'(i & 1), 0, 16'd6, 1, 16'(16'h100 + i),
            3'(i), 4'(8 + i), i < 3, 16'h00AA, 16'(16'h100 + i));
    check("mul_full", {62'd0, mul_count}, 64'd3);
    step();
    check("mul_hold", {62'd0, mul_count}, 64'd3);

    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h00AA;
    step();
    cdb_valid = 1'b0;
    check("mul_woken", {62'd0, mul_count}, 64'd3);
    for (int i = 2; i >= 0; i--) begin
      step();
      check("mul_drain", {62'd0, mul_count}, 64'(i));
    end

    // branch with rs2 bypassed from the CDB at append
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h1234;
    offer(4'b0100, 1, 16'h0011, 0, 16'd4, 3'd5, 4'd1, 1, 16'h0011, 16'h1234);
    cdb_valid = 1'b0;
    check("bch_cnt1", {62'd0, bch_count}, 64'd1);
    step();
    check("bch_cnt0", {62'd0, bch_count}, 64'd0);

    // illegal opcode
    offer(4'b1000, 1, 16'd1, 1, 16'd2, 3'd1, 4'd1, 0, 16'd0, 16'd0);
    check("ill_cnts", {58'd0, add_count, mul_count, bch_count}, 64'd0);

    // fill add pool, wake it, then reset while dispatch is pending
    for (int i = 0; i < 3; i++)
      offer(4'b0001, 0, 16'd5, 1, 16'd0, 3'(i), 4'(i), 1, 16'd0, 16'd0);
    check("add_full", {62'd0, add_count}, 64'd3);
    q_add.delete();
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h0055;
    step();
    cdb_valid = 1'b0;
    count = 1'b1; func = 4'b0000; rs1b = 1; rs2b = 1;
    #1;
    check("full_no_acc", {63'd0, accept}, 64'd0);
    count = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_cnts", {58'd0, add_count, mul_count, bch_count}, 64'd0);
    check("rst2_dv", {61'd0, add_disp_valid, mul_disp_valid, bch_disp_valid}, 64'd0);
    offer(4'b0000, 1, 16'd9, 1, 16'd10, 3'd7, 4'd15, 1, 16'd9, 16'd10);
    check("post_cnt", {62'd0, add_count}, 64'd1);
    step(); step(); step();

    check("add_drained", 64'(q_add.size()), 64'd0);
    check("mul_drained", 64'(q_mul.size()), 64'd0);
    check("bch_drained", 64'(q_bch.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
